// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus a four-state stability FSM that turns a bouncing pin into a clean level.
// Optional DEBOUNCER_LONG_PRESS_EN adds a saturating hold counter that drives long_press.
module button_debouncer #(
  parameter int CNT_WIDTH     = 20,
  parameter int STABLE_CYCLES = 1000000,
  parameter int LONG_WIDTH    = 26,
  parameter int LONG_CYCLES   = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level,
  output logic long_press
);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  // Reject parameter sets where the counters could not hold their terminal values.
  if (STABLE_CYCLES < 2 || longint'(STABLE_CYCLES) > (longint'(1) << CNT_WIDTH)) begin : g_bad_stable
    $error("button_debouncer: STABLE_CYCLES out of range for CNT_WIDTH");
  end
  if (LONG_CYCLES < 1 || longint'(LONG_CYCLES) > ((longint'(1) << LONG_WIDTH) - 1)) begin : g_bad_long
    $error("button_debouncer: LONG_CYCLES out of range for LONG_WIDTH");
  end

  logic                 s1_q, s2_q;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOW: begin
        if (s2_q) begin
          state_d = CHK_HIGH;
          cnt_d   = '0;
        end
      end
      CHK_HIGH: begin
        if (!s2_q) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      HIGH: begin
        if (!s2_q) begin
          state_d = CHK_LOW;
          cnt_d   = '0;
        end
      end
      CHK_LOW: begin
        if (s2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The checking states keep the old level so a bounce never shows up downstream.
  assign level = (state_q == HIGH) || (state_q == CHK_LOW);

`ifdef DEBOUNCER_LONG_PRESS_EN
  localparam logic [LONG_WIDTH-1:0] LONG_LAST = LONG_WIDTH'(LONG_CYCLES);

  logic [LONG_WIDTH-1:0] long_cnt_q, long_cnt_d;

  always_comb begin
    long_cnt_d = long_cnt_q;
    if (state_d == LOW) begin
      long_cnt_d = '0;
    end else if (level && (long_cnt_q != LONG_LAST)) begin
      long_cnt_d = long_cnt_q + LONG_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt_q <= '0;
    end else begin
      long_cnt_q <= long_cnt_d;
    end
  end

  assign long_press = (long_cnt_q == LONG_LAST);
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised bench for button_debouncer: a sample-history model decides when level may flip.
// Honours DEBOUNCER_LONG_PRESS_EN the same way as the design.
module tb_button_debouncer;

  localparam int SC = 4;
  localparam int CW = 3;
  localparam int LC = 10;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic level;
  logic long_press;

  int total = 0;
  int bad   = 0;

  // Reference state: every btn_in value sampled since the last reset release.
  bit hist[$];
  bit level_m    = 1'b0;
  int hi_run     = 0;
  int press_m    = 0;
  int ticks      = 0;
  bit level_prev = 1'b0;

  button_debouncer #(
    .CNT_WIDTH    (CW),
    .STABLE_CYCLES(SC),
    .LONG_WIDTH   (LW),
    .LONG_CYCLES  (LC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .level     (level),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Value the FSM sees at edge j: the pin sampled two edges earlier, zero until the synchroniser fills.
  function automatic bit v_at(input int j);
    return (j >= 2) ? hist[j-2] : 1'b0;
  endfunction

  function automatic bit lp_exp();
`ifdef DEBOUNCER_LONG_PRESS_EN
    return hi_run >= LC + 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive_cycle(input bit b);
    int  k;
    bit  flip;
    btn_in = b;
    @(posedge clk);
    hist.push_back(b);
    k = hist.size() - 1;
    // level flips once SC+1 consecutive FSM samples disagree with it.
    if (k >= SC) begin
      flip = 1'b1;
      for (int i = k - SC; i <= k; i++) begin
        if (v_at(i) == level_m) flip = 1'b0;
      end
      if (flip) begin
        level_m = !level_m;
        if (level_m) press_m++;
      end
    end
    hi_run = level_m ? hi_run + 1 : 0;
    #1;
    check_bit("level", level, level_m);
    check_bit("long_press", long_press, lp_exp());
    if (level && !level_prev) ticks++;
    level_prev = level;
  endtask

  // Called 1 time unit after a rising edge: asserts reset mid-cycle and checks the outputs clear at once.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("rst_level", level, 1'b0);
    check_bit("rst_long", long_press, 1'b0);
    hist.delete();
    level_m    = 1'b0;
    hi_run     = 0;
    level_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rerise_after_reset(input string name);
    for (int i = 0; i < SC + 3; i++) begin
      drive_cycle(1'b1);
      if (i == SC + 1) check_bit({name, "_early"}, level, 1'b0);
      if (i == SC + 2) check_bit({name, "_rise"}, level, 1'b1);
    end
    $display("%s: level=%b after %0d edges with button held", name, level, SC + 3);
  endtask

  initial begin
    int seg_val;
    int seg_len;

    rst_n  = 1'b0;
    btn_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_bit("init_level", level, 1'b0);
    check_bit("init_long", long_press, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    rerise_after_reset("reset_release");

    async_reset();
    rerise_after_reset("midrun_reset");

    // Glitch at rest: SC low samples must not drop level.
    for (int i = 0; i < SC; i++) begin
      drive_cycle(1'b0);
      check_bit("glitch_low", level, 1'b1);
    end
    for (int i = 0; i < SC + 3; i++) begin
      drive_cycle(1'b1);
      check_bit("glitch_recover", level, 1'b1);
    end
    $display("glitch at rest: %0d low samples, level=%b", SC, level);

    // Clean release: level falls after SC+2 edges.
    for (int i = 0; i < SC + 3; i++) begin
      drive_cycle(1'b0);
      if (i == SC + 1) check_bit("release_early", level, 1'b1);
      if (i == SC + 2) check_bit("release_fall", level, 1'b0);
    end
    $display("release: level=%b", level);

    for (int seg = 0; seg < 250; seg++) begin
      seg_val = $urandom_range(0, 1);
      if ($urandom_range(0, 9) < 7) seg_len = $urandom_range(1, SC);
      else seg_len = $urandom_range(SC + 1, SC + 6);
      for (int i = 0; i < seg_len; i++) drive_cycle(seg_val[0]);
      $display("seg %0d: btn=%0d len=%0d level=%b long_press=%b", seg, seg_val, seg_len, level, long_press);
      if ($urandom_range(0, 39) == 0) begin
        async_reset();
        $display("seg %0d: async reset", seg);
      end
    end

    // Long hold, a bounce inside the release check, then a real release.
    for (int i = 0; i < SC + 6; i++) drive_cycle(1'b0);
    for (int i = 0; i < SC + LC + 8; i++) drive_cycle(1'b1);
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b1);
    $display("long hold: level=%b long_press=%b", level, long_press);
    for (int i = 0; i < SC + 6; i++) drive_cycle(1'b0);
    $display("long release: level=%b long_press=%b", level, long_press);

    total++;
    if (ticks != press_m) begin
      bad++;
      $display("FAIL tick_count: got=%0d expected=%0d", ticks, press_m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for raw push-button and switch inputs on the FPGA board.
- Synchronises the asynchronous pin into the clk domain and rejects bounce/glitches.
- Drives a clean, debounced `level` that feeds the rising-edge detector, which turns it into one-cycle `tick` pulses for the multiplier control logic.

Parameters:
- CNT_WIDTH, 20, width of the stability counter.
- STABLE_CYCLES, 1000000, consecutive stable samples needed before `level` changes. Legal range is 2 .. 2^CNT_WIDTH.
- LONG_WIDTH, 26, width of the long-press counter (used only with the optional feature).
- LONG_CYCLES, 50000000, cycles `level` must stay high before `long_press` asserts. Legal range is 1 .. 2^LONG_WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset; clears every register immediately when low.
- btn_in  input  1  raw, asynchronous, bouncing button/switch pin.
- level  output  1  debounced, synchronous version of btn_in.
- long_press  output  1  high while the button has been held beyond LONG_CYCLES; constant 0 when the feature is compiled out.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync flops s1, s2 = 0; state = LOW; cnt = 0; long_cnt = 0.
  - level = 0; long_press = 0.
  - All outputs are registered or decoded from registered state; no combinational path from btn_in.
- Synchroniser:
  - s1 <= btn_in; s2 <= s1. Only s2 is used by the FSM.
- FSM states and level decode:
  - LOW: level = 0. s2=1 -> CHK_HIGH with cnt=0; else stay.
  - CHK_HIGH: level = 0.
    - s2=0 -> LOW, cnt=0.
    - else cnt == STABLE_CYCLES-1 -> HIGH, cnt=0.
    - else cnt <= cnt+1.
  - HIGH: level = 1. s2=0 -> CHK_LOW with cnt=0; else stay.
  - CHK_LOW: level = 1.
    - s2=1 -> HIGH, cnt=0.
    - else cnt == STABLE_CYCLES-1 -> LOW, cnt=0.
    - else cnt <= cnt+1.
  - Unreachable encodings -> LOW.
- Latency:
  - btn_in first sampled high at edge t and held -> level rises after edge t+STABLE_CYCLES+2.
  - Falling edge is symmetric.
- Glitch rejection:
  - btn_in must be stable for STABLE_CYCLES+1 consecutive samples to change level.
  - Any shorter pulse, of either polarity, leaves level unchanged.
  - The counter restarts from 0 on every bounce.
- level changes at most once per STABLE_CYCLES+1 cycles. It never produces single-cycle pulses, so the downstream edge detector emits exactly one tick per accepted press.
- cnt never exceeds STABLE_CYCLES-1; no wrap-around.
- Reset asserted mid-count: the count is discarded, and level returns to 0 asynchronously even if the button is held. After reset release with the button still held, a full debounce interval is required again (level re-rises after STABLE_CYCLES+3 edges).

Optional Feature:
- Macro: DEBOUNCER_LONG_PRESS_EN.
- Defined:
  - long_cnt increments every cycle the state is HIGH or CHK_LOW, saturating at LONG_CYCLES.
  - long_press = 1 when long_cnt == LONG_CYCLES.
  - long_cnt clears to 0 on entry to LOW.
  - long_press therefore stays high until level falls, and drops in the same cycle level falls.
  - A bounce during CHK_LOW that returns to HIGH does not clear long_cnt.
- Undefined: long_cnt logic is absent and long_press is tied to 0.

Test Plan (STABLE_CYCLES=4, CNT_WIDTH=3, LONG_CYCLES=10, LONG_WIDTH=4):
- Reset with btn_in=1: assert rst_n=0 mid-cycle -> level=0 and long_press=0 immediately. Release at edge 0 with btn held -> level=1 after edge 6.
- Clean press: btn_in 0->1 sampled at edge 10 and held -> level=0 through edge 15, level=1 after edge 16. A downstream edge detector gives exactly one tick.
- Bounce: btn_in high for 4 samples, low for 1, then high steadily from edge 20 -> level stays 0 until after edge 26. The first burst never raises level.
- Glitch at rest: level=1, btn_in low for exactly 4 samples (edges 40-43), then high -> level stays 1 throughout.
- Release: level=1, btn_in low held from edge 50 -> level=0 after edge 56.
- Long press (macro defined): level rises after edge 16, btn held -> long_press=1 after edge 26 and stays high. Release sampled at edge 40 -> long_press and level both 0 after edge 46. With the macro undefined, long_press stays 0 for the same stimulus.
